// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer: host opcodes,
// datapath mode selects and controller FSM states.
package usr_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Command handshake, serial fill and status bundle between a host and the
// shift-register sequencer.
interface usr_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, sin_r, sin_l,
    input  cmd_ready, q, sout, sout_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, sin_r, sin_l,
    output cmd_ready, q, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/dflipflop.sv
// Single D flip-flop cell with synchronous active-low clear.
module dflipflop (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end
endmodule

// File: rtl/usr_core.sv
// WIDTH-bit universal shift register: one dflipflop per bit behind a 4:1 mux
// selecting hold, right neighbour, left neighbour or parallel input.
module usr_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  mode_t            mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q
);
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic right_in;
      logic left_in;
      logic d_bit;

      // Edge bits take the serial fill instead of a neighbour.
      if (gi == WIDTH - 1) begin : g_msb
        assign right_in = sin_r;
      end else begin : g_mid_r
        assign right_in = q[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign left_in = sin_l;
      end else begin : g_mid_l
        assign left_in = q[gi-1];
      end

      always_comb begin
        d_bit = q[gi];
        case (mode)
          MODE_SHR:  d_bit = right_in;
          MODE_SHL:  d_bit = left_in;
          MODE_LOAD: d_bit = pin[gi];
          default:   d_bit = q[gi];
        endcase
      end

      dflipflop u_ff (
        .clk   (clk),
        .reset (reset),
        .d     (d_bit),
        .q     (q[gi])
      );
    end
  endgenerate
endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer: accepts one HOLD/SHR/SHL/LOAD command at a time, steps the
// shift register mode per cycle, streams shifted-out bits and pulses done.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 2
) (
  input  logic           clk,
  input  logic           reset,
  usr_seq_ctrl_if.slave  bus
);
  state_t           state;
  mode_t            mode;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             sout_valid;
  logic             done;

  // mode doubles as the latched opcode: it is non-HOLD only while in EXEC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mode       <= MODE_HOLD;
      remaining  <= '0;
      data       <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      sout_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            data <= bus.cmd_data;
            case (op_t'(bus.cmd_op))
              OP_LOAD: begin
                mode      <= MODE_LOAD;
                remaining <= CNT_W'(1);
                state     <= ST_EXEC;
              end
              OP_SHR, OP_SHL: begin
                if (bus.cmd_cnt != '0) begin
                  mode      <= (op_t'(bus.cmd_op) == OP_SHR) ? MODE_SHR : MODE_SHL;
                  remaining <= bus.cmd_cnt;
                  state     <= ST_EXEC;
                end else begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              end
              default: begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        ST_EXEC: begin
          remaining <= remaining - CNT_W'(1);
          if (mode == MODE_SHR) begin
            sout       <= q[0];
            sout_valid <= 1'b1;
          end else if (mode == MODE_SHL) begin
            sout       <= q[WIDTH-1];
            sout_valid <= 1'b1;
          end
          if (remaining == CNT_W'(1)) begin
            state <= ST_DONE;
            mode  <= MODE_HOLD;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  usr_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .sin_r (bus.sin_r),
    .sin_l (bus.sin_l),
    .pin   (data),
    .q     (q)
  );

  assign bus.cmd_ready  = (state == ST_IDLE) && reset;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.q          = q;
  assign bus.sout       = sout;
  assign bus.sout_valid = sout_valid;
  assign bus.done       = done;
endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench for usr_seq_ctrl: directed table, reset/abort sequences
// and random commands against an arithmetic model of the shift register.
module tb_usr_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   mq;
  int   msout;

  usr_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] cnt;
    logic [3:0] data;
    logic       sr;
    logic       sl;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of one register step using plain integer arithmetic.
  task automatic model_step(input int op, input int sr, input int sl, input int data);
    if (op == 3) begin
      mq = data;
    end else if (op == 1) begin
      msout = mq % 2;
      mq    = mq / 2 + sr * (1 << (WIDTH - 1));
    end else if (op == 2) begin
      msout = (mq >= (1 << (WIDTH - 1))) ? 1 : 0;
      mq    = (mq * 2) % (1 << WIDTH) + sl;
    end
  endtask

  // Entered and left at a falling edge with the controller idle.
  task automatic exec_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [3:0] data,
                          input logic sr, input logic sl, input bit rnd);
    int n;
    int shift;
    int cur_r;
    int cur_l;
    n     = (op == 2'b11) ? 1 : (op == 2'b00) ? 0 : int'(cnt);
    shift = (op == 2'b01 || op == 2'b10) ? 1 : 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    bus.cmd_data  = data;
    bus.sin_r     = sr;
    bus.sin_l     = sl;
    #1 chk("ready_before_accept", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    // Junk command held during the busy window must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_cnt   = 4'($urandom);
    bus.cmd_data  = 4'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("done_after_accept", 32'(bus.done), 32'(n == 0));
    chk("sout_valid_after_accept", 32'(bus.sout_valid), 32'd0);
    chk("q_after_accept", 32'(bus.q), 32'(mq));
    chk("ready_while_busy", 32'(bus.cmd_ready), 32'd0);
    for (int k = 1; k <= n; k++) begin
      if (rnd) begin
        bus.sin_r = 1'($urandom);
        bus.sin_l = 1'($urandom);
      end
      cur_r = int'(bus.sin_r);
      cur_l = int'(bus.sin_l);
      @(negedge clk);
      model_step(int'(op), cur_r, cur_l, int'(data));
      chk("q_step", 32'(bus.q), 32'(mq));
      chk("sout_valid_step", 32'(bus.sout_valid), 32'(shift));
      if (shift == 1) chk("sout_step", 32'(bus.sout), 32'(msout));
      chk("done_step", 32'(bus.done), 32'(k == n));
      chk("busy_step", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("done_end", 32'(bus.done), 32'd0);
    chk("ready_end", 32'(bus.cmd_ready), 32'd1);
    chk("sout_valid_end", 32'(bus.sout_valid), 32'd0);
    chk("sout_hold_end", 32'(bus.sout), 32'(msout));
    chk("q_end", 32'(bus.q), 32'(mq));
    bus.cmd_valid = 1'b0;
    $display("[TB] cmd op=%0d cnt=%0d data=%h -> q=%h sout=%0d", op, cnt, data, bus.q, bus.sout);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mq    = 0;
    msout = 0;
    vecs[0] = '{op: 2'b11, cnt: 4'd0, data: 4'b1011, sr: 1'b0, sl: 1'b0, exp_q: 4'b1011};
    vecs[1] = '{op: 2'b01, cnt: 4'd2, data: 4'b0000, sr: 1'b1, sl: 1'b0, exp_q: 4'b1110};
    vecs[2] = '{op: 2'b10, cnt: 4'd4, data: 4'b0000, sr: 1'b0, sl: 1'b0, exp_q: 4'b0000};
    vecs[3] = '{op: 2'b01, cnt: 4'd0, data: 4'b1111, sr: 1'b1, sl: 1'b1, exp_q: 4'b0000};
    vecs[4] = '{op: 2'b00, cnt: 4'd7, data: 4'b1111, sr: 1'b1, sl: 1'b1, exp_q: 4'b0000};
    vecs[5] = '{op: 2'b11, cnt: 4'd9, data: 4'b1001, sr: 1'b0, sl: 1'b0, exp_q: 4'b1001};
    vecs[6] = '{op: 2'b10, cnt: 4'd6, data: 4'b0000, sr: 1'b0, sl: 1'b1, exp_q: 4'b1111};
    vecs[7] = '{op: 2'b01, cnt: 4'd5, data: 4'b0000, sr: 1'b0, sl: 1'b1, exp_q: 4'b0000};

    // Reset held low while a LOAD is offered.
    reset         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_cnt   = 4'd0;
    bus.cmd_data  = 4'b1111;
    bus.sin_r     = 1'b0;
    bus.sin_l     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_q", 32'(bus.q), 32'd0);
    chk("reset_ready", 32'(bus.cmd_ready), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_sout_valid", 32'(bus.sout_valid), 32'd0);
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    #1 chk("release_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    chk("release_q", 32'(bus.q), 32'd0);
    chk("release_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      exec_cmd(vecs[i].op, vecs[i].cnt, vecs[i].data, vecs[i].sr, vecs[i].sl, 1'b0);
      chk("table_final_q", 32'(bus.q), 32'(vecs[i].exp_q));
    end

    // Abort a left shift with reset after two steps.
    exec_cmd(2'b11, 4'd0, 4'b0110, 1'b0, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_cnt   = 4'd4;
    bus.sin_l     = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_q1", 32'(bus.q), 32'b1101);
    @(negedge clk);
    chk("abort_q2", 32'(bus.q), 32'b1011);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_q", 32'(bus.q), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ready_low", 32'(bus.cmd_ready), 32'd0);
    chk("abort_sout_valid", 32'(bus.sout_valid), 32'd0);
    chk("abort_sout", 32'(bus.sout), 32'd0);
    reset = 1'b1;
    #1 chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    mq    = 0;
    msout = 0;
    exec_cmd(2'b11, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b0);
    chk("post_abort_load", 32'(bus.q), 32'b0001);

    for (int i = 0; i < 40; i++) begin
      exec_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom),
               1'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle_gap_q", 32'(bus.q), 32'(mq));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
Command sequencer for the WIDTH-bit universal shift register built from dflipflop cells. It accepts one command at a time over a valid/ready handshake: parallel load, hold, or shift left/right by a programmed count. It then drives the register mode select cycle by cycle. It streams out each shifted-out bit and pulses done on completion. It sits between a host/test controller and the shift-register datapath.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, $clog2(WIDTH)+2, width of shift-count field (derived; counts up to 2^CNT_W-1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous reset, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 HOLD, 01 SHR, 10 SHL, 11 LOAD
cmd_cnt  input  CNT_W  number of shift steps (SHR/SHL only)
cmd_data  input  WIDTH  parallel load word (LOAD only)
sin_r  input  1  serial fill into MSB on right shift
sin_l  input  1  serial fill into LSB on left shift
q  output  WIDTH  register contents
sout  output  1  last bit shifted out
sout_valid  output  1  sout updated this cycle
busy  output  1  command in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, q=0, sout=0, sout_valid=0, done=0, busy=0. cmd_ready=0 while reset is low. Reset mid-command aborts immediately; no done pulse is issued.
- Mode encoding to the datapath: 00 hold, 01 shift right, 10 shift left, 11 parallel load. The mode is HOLD in every cycle except EXEC.
- FSM states: IDLE, EXEC, DONE.
- cmd_ready = (state==IDLE) && reset. busy = (state!=IDLE).
- Accept on edge where cmd_valid && cmd_ready. At acceptance, latch op, cnt and data.
  - op LOAD goes to EXEC with remaining=1.
  - op SHR/SHL goes to EXEC with remaining=cnt if cnt!=0, else to DONE.
  - op HOLD goes to DONE.
- EXEC: each edge applies one step and decrements remaining. When remaining==1, go to DONE.
  - LOAD: q<=data.
  - SHR: q<={sin_r,q[WIDTH-1:1]}, sout<=q[0].
  - SHL: q<={q[WIDTH-2:0],sin_l}, sout<=q[WIDTH-1].
  - Serial inputs are sampled at the step edge.
- sout_valid is registered. It is 1 in the cycle after each shift edge, 0 otherwise. sout holds its value between shifts.
- DONE: done=1 for exactly this cycle, then go to IDLE (ready again the next cycle).
- Latency: a shift of n≥1 steps changes q on edges 1..n after acceptance. done is high in the cycle after edge n. cmd_ready returns after edge n+1. LOAD behaves as n=1.
- Zero-count shift or HOLD: q unchanged, no sout_valid, done in the cycle after acceptance.
- Counts greater than WIDTH are legal. Extra steps keep shifting fill bits; there is no clamp and no error.
- cmd_valid while busy is ignored; the requester must hold the command until it is accepted.
- cmd_* inputs are not sampled after acceptance, so changing them mid-command has no effect.

Decomposition:
- Package usr_pkg: op encodings (OP_HOLD, OP_SHR, OP_SHL, OP_LOAD), datapath mode encodings (MODE_HOLD=00, MODE_SHR=01, MODE_SHL=10, MODE_LOAD=11), FSM state encodings.
- Sub-module usr_core: WIDTH-bit universal shift register instantiating dflipflop cells with a per-bit 4:1 mux.
  - Inputs: clk, reset, mode[1:0], sin_r, sin_l, pin.
  - Output: q.
  - Uses the same synchronous active-low reset.
- usr_seq_ctrl contains only the FSM, counter and sout logic, and drives usr_core.

Test Plan:
1. Hold reset low for 2 cycles with cmd_valid=1, op=LOAD, data=1111 -> q=0000, cmd_ready=0, done=0, busy=0. After release: cmd_ready=1, q still 0000.
2. LOAD data=1011 -> q=1011 one edge after acceptance. done pulses once in the following cycle, sout_valid stays 0, and cmd_ready returns the cycle after that.
3. From 1011, SHR cnt=2 with sin_r=1 -> q=1101 then 1110. sout=1 and 1, with sout_valid high for 2 cycles. Single done pulse.
4. From 1110, SHL cnt=4 with sin_l=0 -> q=1100, 1000, 0000, 0000. sout=1, 1, 1, 0. busy high for 5 cycles.
5. SHR cnt=0, and separately HOLD -> q unchanged, no sout_valid, done in the cycle after acceptance. A cmd_valid pulse while busy is not accepted.
6. LOAD 0110, then SHL cnt=4 with sin_l=1, then assert reset after 2 shifts -> q=0000 after the reset edge. No done pulse. cmd_ready=1 after release, and the next LOAD 0001 completes normally.
